frame_scanout: RTL and testbench

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/frame_scanout.sv | 115 +++++++++++
 tb/tb_frame_scanout.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout.sv
// VGA 640x480 scan-out: a pixel tick at half the Clk rate drives the raster counters, and
// every sync, blank and pixel output is registered on the tick=1 edge from the pre-increment counters.
module frame_scanout #(
   parameter int H_VISIBLE    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 751,
   parameter int H_TOTAL      = 800,
   parameter int V_VISIBLE    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_END   = 491,
   parameter int V_TOTAL      = 525
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        data_In,
   output logic [18:0] read_address,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        blank_n,
   output logic        pixel_on,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        pixel_clk,
   output logic        frame_start
);

   logic       tick_q, tick_d;
   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       visible;

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       pix_q, pix_d;
   logic       fs_q, fs_d;

   // Raster counters: advance once per pixel period, wrapping with no idle cycle.
   always_comb begin
      tick_d = ~tick_q;
      hc_d   = hc_q;
      vc_d   = vc_q;
      if (tick_q) begin
         if (hc_q == 10'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   assign visible = (hc_q < 10'(H_VISIBLE)) && (vc_q < 10'(V_VISIBLE));

   // The RAM latches this on the tick=0 edge, so its data is ready at the next tick=1 edge.
   assign read_address = visible ? (19'(vc_q) * 19'(H_VISIBLE) + 19'(hc_q)) : '0;

   // Output stage: loads on tick=1 edges and holds otherwise; frame_start self-clears.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      blank_d = blank_q;
      pix_d   = pix_q;
      fs_d    = 1'b0;
      if (tick_q) begin
         x_d     = hc_q;
         y_d     = vc_q;
         blank_d = visible;
         hs_d    = !((hc_q >= 10'(H_SYNC_START)) && (hc_q <= 10'(H_SYNC_END)));
         vs_d    = !((vc_q >= 10'(V_SYNC_START)) && (vc_q <= 10'(V_SYNC_END)));
         pix_d   = visible & data_In;
         fs_d    = (hc_q == '0) && (vc_q == '0);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         tick_q  <= 1'b0;
         hc_q    <= '0;
         vc_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         pix_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         tick_q  <= tick_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         pix_q   <= pix_d;
         fs_q    <= fs_d;
      end
   end

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign blank_n     = blank_q;
   assign pixel_on    = pix_q;
   assign pixel_clk   = tick_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: a full-size instance for line timing and pixel data, plus a
// miniature-raster instance so frame wrap, vertical sync and frame_start spacing fit in a short run.
module tb_frame_scanout;

   localparam int S_HV  = 8;
   localparam int S_HSS = 10;
   localparam int S_HSE = 12;
   localparam int S_HT  = 20;
   localparam int S_VV  = 6;
   localparam int S_VSS = 8;
   localparam int S_VSE = 9;
   localparam int S_VT  = 12;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       pix;
      logic       fs;
   } pix_t;

   typedef struct {
      int          inst;
      int          hc;
      int          vc;
      logic [18:0] addr;
   } vec_t;

   localparam pix_t RST_REC = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, pix: 1'b0, fs: 1'b0};

   int ht_a[2]  = '{800, S_HT};
   int hv_a[2]  = '{640, S_HV};
   int hss_a[2] = '{656, S_HSS};
   int hse_a[2] = '{751, S_HSE};
   int vt_a[2]  = '{525, S_VT};
   int vv_a[2]  = '{480, S_VV};
   int vss_a[2] = '{490, S_VSS};
   int vse_a[2] = '{491, S_VSE};

   logic clk;
   logic rst_b, rst_sm;
   logic din_b, din_s;
   logic [18:0] addr_b, addr_s;
   logic hs_b, vs_b, blank_b, pix_b, pclk_b, fs_b;
   logic hs_s, vs_s, blank_s, pix_s, pclk_s, fs_s;
   logic [9:0] dx_b, dy_b, dx_s, dy_s;
   pix_t obs_b, obs_s;

   frame_scanout u_big (
      .Clk(clk), .Reset(rst_b), .data_In(din_b), .read_address(addr_b),
      .VGA_HS(hs_b), .VGA_VS(vs_b), .blank_n(blank_b), .pixel_on(pix_b),
      .DrawX(dx_b), .DrawY(dy_b), .pixel_clk(pclk_b), .frame_start(fs_b)
   );

   frame_scanout #(
      .H_VISIBLE(S_HV), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
      .V_VISIBLE(S_VV), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT)
   ) u_small (
      .Clk(clk), .Reset(rst_sm), .data_In(din_s), .read_address(addr_s),
      .VGA_HS(hs_s), .VGA_VS(vs_s), .blank_n(blank_s), .pixel_on(pix_s),
      .DrawX(dx_s), .DrawY(dy_s), .pixel_clk(pclk_s), .frame_start(fs_s)
   );

   assign obs_b = {dx_b, dy_b, blank_b, hs_b, vs_b, pix_b, fs_b};
   assign obs_s = {dx_s, dy_s, blank_s, hs_s, vs_s, pix_s, fs_s};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic mem_fn(logic [18:0] a);
      return a[0] ^ a[10];
   endfunction

   // One-cycle-latency frame-buffer models.
   always @(posedge clk) begin
      din_b <= mem_fn(addr_b);
      din_s <= mem_fn(addr_s);
   end

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic rst_q[2];
   int   tpos[2], npix[2], nfs[2];
   bit   active[2] = '{0, 0};
   bit   nxt_pclk[2];
   pix_t prev[2];
   pix_t sb0[$], sb1[$];
   int   hs_cnt = 0, blank_cnt = 0, line_cnt = 0;
   int   vs_cnt = 0, frame_cnt = 0;
   int   fs_t[16];
   vec_t tab[11];

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_q[0] <= rst_b;
      rst_q[1] <= rst_sm;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic pix_t exp_pix(int i, int pos);
      pix_t r;
      int   x, y;
      x       = pos % ht_a[i];
      y       = (pos / ht_a[i]) % vt_a[i];
      r.x     = 10'(x);
      r.y     = 10'(y);
      r.blank = (x < hv_a[i]) && (y < vv_a[i]);
      r.hs    = !((x >= hss_a[i]) && (x <= hse_a[i]));
      r.vs    = !((y >= vss_a[i]) && (y <= vse_a[i]));
      r.pix   = r.blank ? mem_fn(19'(y * hv_a[i] + x)) : 1'b0;
      r.fs    = (x == 0) && (y == 0);
      return r;
   endfunction

   function automatic logic [18:0] exp_addr(int i, int pos);
      int x, y;
      x = pos % ht_a[i];
      y = (pos / ht_a[i]) % vt_a[i];
      return ((x < hv_a[i]) && (y < vv_a[i])) ? 19'(y * hv_a[i] + x) : 19'd0;
   endfunction

   // Scoreboard: the expected pixel is queued when the RAM samples its address and
   // popped when the DUT registers that pixel one edge later.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         pix_t        cur, hold, e;
         logic [18:0] cur_addr;
         logic        cur_pclk;
         cur      = (i == 0) ? obs_b : obs_s;
         cur_addr = (i == 0) ? addr_b : addr_s;
         cur_pclk = (i == 0) ? pclk_b : pclk_s;
         if (rst_q[i] === 1'b1) begin
            active[i]   = 1'b1;
            tpos[i]     = 0;
            npix[i]     = 0;
            nxt_pclk[i] = 1'b1;
            if (i == 0) sb0.delete(); else sb1.delete();
            chk("reset_state", {cur, cur_pclk, cur_addr}, {RST_REC, 1'b0, 19'd0});
            prev[i] = RST_REC;
         end else if (active[i]) begin
            chk("pixel_clk", cur_pclk, nxt_pclk[i]);
            if (nxt_pclk[i]) begin
               hold    = prev[i];
               hold.fs = 1'b0;
               chk("hold", cur, hold);
               if (i == 0) sb0.push_back(exp_pix(i, tpos[i]));
               else        sb1.push_back(exp_pix(i, tpos[i]));
            end else begin
               if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL scoreboard_empty inst %0d @%0t", i, $time);
               end else begin
                  e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                  chk($sformatf("pixel%0d_%0d_%0d", i, e.x, e.y), cur, e);
               end
               tpos[i]++;
               npix[i]++;
            end
            chk("read_address", cur_addr, exp_addr(i, tpos[i]));
            prev[i]     = cur;
            nxt_pclk[i] = !nxt_pclk[i];
            if (cur.fs === 1'b1) begin
               nfs[i]++;
               if (i == 1 && nfs[1] < 16) fs_t[nfs[1]] = cyc;
            end
            if (i == 0 && nfs[0] == 1 && cur.y == 10'd0) begin
               line_cnt++;
               if (!cur.hs) hs_cnt++;
               if (cur.blank) blank_cnt++;
            end
            if (i == 1 && nfs[1] == 1) begin
               frame_cnt++;
               if (!cur.vs) vs_cnt++;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_pos(input int i, input int p);
      int budget;
      budget = 20000;
      while (tpos[i] != p && budget > 0) begin
         step();
         budget--;
      end
      if (budget == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_pos inst %0d: stuck at %0d, target %0d", i, tpos[i], p);
      end
   endtask

   initial begin
      tab[0]  = '{1, 8, 0, 19'd0};
      tab[1]  = '{1, 7, 5, 19'd47};
      tab[2]  = '{1, 0, 6, 19'd0};
      tab[3]  = '{1, 19, 11, 19'd0};
      tab[4]  = '{0, 639, 0, 19'd639};
      tab[5]  = '{0, 640, 0, 19'd0};
      tab[6]  = '{0, 0, 1, 19'd640};
      tab[7]  = '{0, 1, 1, 19'd641};
      tab[8]  = '{0, 639, 1, 19'd1279};
      tab[9]  = '{0, 5, 2, 19'd1285};
      tab[10] = '{0, 656, 2, 19'd0};
      nfs    = '{0, 0};
      rst_b  = 1'b1;
      rst_sm = 1'b1;
      repeat (4) @(posedge clk);
      step();
      rst_b  = 1'b0;
      rst_sm = 1'b0;

      for (int k = 0; k < 11; k++) begin
         wait_pos(tab[k].inst, tab[k].vc * ht_a[tab[k].inst] + tab[k].hc);
         chk($sformatf("addr_tab%0d", k), (tab[k].inst == 0) ? addr_b : addr_s, tab[k].addr);
      end

      chk("hs_low_clk", hs_cnt, 192);
      chk("blank_clk", blank_cnt, 1280);
      chk("line_clk", line_cnt, 1600);
      chk("fs_interval", fs_t[2] - fs_t[1], 2 * S_HT * S_VT);
      chk("vs_low_clk", vs_cnt, 2 * 2 * S_HT);
      chk("frame_clk", frame_cnt, 2 * S_HT * S_VT);

      // Mid-frame abort of the miniature raster at (5,3).
      wait_pos(1, 10 * S_HT * S_VT + 3 * S_HT + 5);
      rst_sm = 1'b1;
      repeat (3) step();
      rst_sm = 1'b0;

      // Mid-line abort of the full raster at (300,3), then the restart sequence.
      wait_pos(0, 3 * 800 + 300);
      rst_b = 1'b1;
      repeat (3) step();
      chk("rst_hold_outputs", {obs_b, pclk_b}, {RST_REC, 1'b0});
      rst_b = 1'b0;
      step();
      chk("rel_edge1_fs", fs_b, 1'b0);
      chk("rel_edge1_pclk", pclk_b, 1'b1);
      chk("rel_edge1_xy", {dx_b, dy_b, blank_b}, 21'd0);
      step();
      chk("rel_edge2_fs", fs_b, 1'b1);
      chk("rel_edge2_xy", {dx_b, dy_b}, 20'd0);
      chk("rel_edge2_sync", {hs_b, vs_b, blank_b}, 3'b111);
      step();
      chk("rel_edge3_fs", fs_b, 1'b0);

      repeat (2000) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
